ifu_axi_rd_arb: RTL
===================

// Module: ifu_axi_rd_arb
// PURPOSE
// - Shares one AXI4 read master port between two requesters: port 0 = IFU instruction fetch, port 1 = LSU/debug load.
// - Sits between the fetch/load AXI masters and the core bus fabric.
// - Arbitrates AR, extends ARID by one routing bit, steers R beats back by that bit.
// - Tracks outstanding bursts per port and throttles at MAX_OUTS.
// PARAMETERS
// ID_W      `BUS_ID_WIDTH    requester ARID/RID width; downstream width is ID_W+1
// ADDR_W    `BUS_ADDR_WIDTH  address width
// DATA_W    `BUS_DATA_WIDTH  read data width (64)
// MAX_OUTS  4                max outstanding bursts per port (>=1)
// PORTS
// clk                                     in   1       clock, rising edge
// rst                                     in   1       synchronous reset, active-high
// sN_arid/araddr/arlen/arsize/arburst     in   ID_W/ADDR_W/8/3/2  port N AR payload (N=0,1)
// sN_arvalid                              in   1       port N AR valid
// sN_arready                              out  1       port N AR ready
// sN_rid/rdata/rresp/rlast                out  ID_W/DATA_W/2/1    port N R payload
// sN_rvalid                               out  1       port N R valid
// sN_rready                               in   1       port N R ready
// m_arid                                  out  ID_W+1  {port bit, sN_arid}
// m_araddr/arlen/arsize/arburst           out  ADDR_W/8/3/2       granted payload
// m_arvalid                               out  1       downstream AR valid
// m_arready                               in   1       downstream AR ready
// m_rid/rdata/rresp/rlast/rvalid          in   ID_W+1/DATA_W/2/1/1 downstream R
// m_rready                                out  1       downstream R ready
// BEHAVIOUR
// - Clock clk; reset rst is synchronous, active-high.
// - Reset: FSM=IDLE, rr_last=1 (port 0 wins first tie), cnt0=cnt1=0.
//   All valid/ready outputs 0; payload outputs 0.
// - AR FSM states: IDLE and HOLD(g).
//   - IDLE: eligible_N = sN_arvalid && cntN<MAX_OUTS.
//     - One eligible port: grant it.
//     - Both eligible: grant !rr_last.
//     - Grant registers g, latches the payload, and goes to HOLD next cycle. AR latency is 1 cycle.
//   - HOLD(g): m_arvalid=1 with the latched payload held stable (AXI rule); sg_arready=0.
//     - On m_arvalid&&m_arready: pulse sg_arready for exactly that cycle, which consumes the source beat.
//     - Same edge: cnt_g++, rr_last=g, return to IDLE.
//     - No back-to-back issue: max 1 AR per 2 cycles.
//   - Requester contract: payload stable from sN_arvalid until sN_arready.
//   - Requester contract: no AR withdrawal once valid.
// - R path, combinational, zero latency:
//   - p = m_rid[ID_W]. s_p_rvalid = m_rvalid; s_p_* = m_r* with rid = m_rid[ID_W-1:0].
//   - m_rready = s_p_rready. The other port's rvalid is 0.
// - Counters:
//   - cntN-- on m_rvalid&&m_rready&&m_rlast with p==N.
//   - Inc and dec in the same cycle leave cntN unchanged.
//   - cntN==MAX_OUTS blocks new grants to N only; the other port is unaffected.
//   - A response for port N when cntN==0 is a protocol error: simulation assertion; counter saturates at 0.
// - Reset mid-burst: FSM/counters clear immediately. The fabric must be reset in the same cycle; there is no drain.
// - IFU jump/flush does not alter the arbiter. Stale fetch responses are still routed to port 0 and counted down.
// STRUCTURE
// - Shared package ifu_bus_pkg:
//   - typedef ar_payload_t (id, addr, len, size, burst).
//   - enum arb_state_e {ARB_IDLE, ARB_HOLD}.
//   - localparam ARB_PORT_IFU=0, ARB_PORT_LSU=1.
// - Sub-module ifu_axi_rd_otcnt, instantiated twice: the saturating outstanding counter with inc/dec/full.
// TESTING
// - Reset: assert rst 2 cycles with s0/s1_arvalid=1 -> all *valid/*ready=0.
//   First cycle after: port 0 granted, m_arid={1'b0,s0_arid}.
// - Round-robin: both ports request continuously with m_arready=1.
//   Grants alternate 0,1,0,1. m_arid[ID_W] toggles. Each sN_arready is a 1-cycle pulse every 4 cycles.
// - Backpressure: m_arready=0 for 5 cycles in HOLD.
//   m_araddr stays 0x8000_0010 stable; s0_arready=0 until the cycle m_arready=1.
// - Throttle: MAX_OUTS=4, port 0 issues 4 ARs, no R returned.
//   5th port-0 request is not granted; port-1 request is granted.
//   One RLAST to port 0 -> the next port-0 grant follows.
// - Routing: m_rid=3'b1_01, 2-beat burst; s1_rready low beat 1.
//   s1_rvalid=1, s0_rvalid=0, s1_rid=2'b01, m_rready=0 during the stall. cnt1 drops on the rlast beat only.
// - Simultaneous: AR handshake for port 0 in the same cycle as port-0 RLAST -> cnt0 unchanged.

Source files
------------

// File: rtl/ifu_bus_pkg.sv
// ifu_bus_pkg: types and constants shared by the IFU read-arbiter slice.
//   BUS_*_W      : bus widths the AR payload struct is built from
//   ARB_PORT_*   : routing-bit value for each requester (also the extra ARID MSB)
//   ar_payload_t : latched AR beat (id, addr, len, size, burst)
//   arb_state_e  : AR arbitration FSM states
package ifu_bus_pkg;

  localparam int unsigned BUS_ID_W   = 2;
  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 64;

  localparam logic ARB_PORT_IFU = 1'b0;
  localparam logic ARB_PORT_LSU = 1'b1;

  typedef struct packed {
    logic [BUS_ID_W-1:0]   id;
    logic [BUS_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_payload_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/ifu_axi_rd_arb_if.sv
// ifu_axi_rd_arb_if: AXI4 read address + read data channels.
//   AR: arid, araddr, arlen, arsize, arburst, arvalid (master->slave), arready (slave->master)
//   R : rid, rdata, rresp, rlast, rvalid (slave->master), rready (master->slave)
// modport master: the side issuing AR and sinking R.
// modport slave : the side accepting AR and returning R.
interface ifu_axi_rd_arb_if
  import ifu_bus_pkg::*;
#(
  parameter int unsigned ID_W   = BUS_ID_W,
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W
);

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/ifu_axi_rd_otcnt.sv
// ifu_axi_rd_otcnt: per-port outstanding-burst counter, saturating at 0 and MAX_OUTS.
//   clk    in  clock
//   rst    in  synchronous active-high reset (count -> 0)
//   i_inc  in  AR beat accepted downstream for this port
//   i_dec  in  RLAST beat accepted for this port
//   o_full out count == MAX_OUTS, blocks new grants to this port
module ifu_axi_rd_otcnt #(
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTS);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    w_cnt_d = r_cnt;
    if (i_inc && !i_dec && (r_cnt != CNT_MAX)) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_full = (r_cnt == CNT_MAX);

  // A response with nothing outstanding means the fabric misrouted or replayed a burst.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_dec && (r_cnt == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                  !(i_inc && !i_dec && (r_cnt == CNT_MAX)));

endmodule

// File: rtl/ifu_axi_rd_arb.sv
// ifu_axi_rd_arb: shares one AXI4 read master between IFU fetch (port 0) and LSU/debug (port 1).
//   clk     in  clock, rising edge
//   rst     in  synchronous reset, active-high
//   s0_bus  slave  port 0 (IFU) AR in / R out, ID width ID_W
//   s1_bus  slave  port 1 (LSU) AR in / R out, ID width ID_W
//   m_bus   master downstream AR out / R in, ID width ID_W+1 ({port bit, source id})
// AR: round-robin grant from IDLE, payload latched and held in HOLD until m_arready.
// R : combinational steering by m_rid[ID_W]; per-port counters throttle at MAX_OUTS.
// ID_W/ADDR_W must match the package widths that size ar_payload_t.
module ifu_axi_rd_arb
  import ifu_bus_pkg::*;
#(
  parameter int unsigned ID_W     = BUS_ID_W,
  parameter int unsigned ADDR_W   = BUS_ADDR_W,
  parameter int unsigned DATA_W   = BUS_DATA_W,
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  ifu_axi_rd_arb_if.slave  s0_bus,
  ifu_axi_rd_arb_if.slave  s1_bus,
  ifu_axi_rd_arb_if.master m_bus
);

  arb_state_e  r_state, w_state_d;
  logic        r_gnt;
  logic        r_rr_last;
  ar_payload_t r_payload;
  ar_payload_t w_pick_payload;

  logic              w_full0, w_full1;
  logic              w_elig0, w_elig1, w_any, w_pick;
  logic              w_ar_hs;
  logic              w_rport;
  logic              w_rlast_hs;
  logic [DATA_W-1:0] w_rdata;

  assign w_elig0 = s0_bus.arvalid && !w_full0;
  assign w_elig1 = s1_bus.arvalid && !w_full1;
  assign w_any   = w_elig0 || w_elig1;
  // Port 1 wins when it is the only candidate, or on a tie when port 0 was served last.
  assign w_pick  = w_elig1 && (!w_elig0 || (r_rr_last == ARB_PORT_IFU));

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ARB_IDLE: if (w_any) w_state_d = ARB_HOLD;
      ARB_HOLD: if (m_bus.arready) w_state_d = ARB_IDLE;
      default:  w_state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    if (w_pick) begin
      w_pick_payload.id    = s1_bus.arid;
      w_pick_payload.addr  = s1_bus.araddr;
      w_pick_payload.len   = s1_bus.arlen;
      w_pick_payload.size  = s1_bus.arsize;
      w_pick_payload.burst = s1_bus.arburst;
    end else begin
      w_pick_payload.id    = s0_bus.arid;
      w_pick_payload.addr  = s0_bus.araddr;
      w_pick_payload.len   = s0_bus.arlen;
      w_pick_payload.size  = s0_bus.arsize;
      w_pick_payload.burst = s0_bus.arburst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= ARB_PORT_IFU;
      r_rr_last <= ARB_PORT_LSU;
      r_payload <= '0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == ARB_IDLE) && w_any) begin
        r_gnt     <= w_pick;
        r_payload <= w_pick_payload;
      end
      if (w_ar_hs) begin
        r_rr_last <= r_gnt;
      end
    end
  end

  // AR downstream: payload comes only from the latch, so it is stable across backpressure.
  assign m_bus.arvalid = (r_state == ARB_HOLD);
  assign m_bus.arid    = {r_gnt, r_payload.id};
  assign m_bus.araddr  = ADDR_W'(r_payload.addr);
  assign m_bus.arlen   = r_payload.len;
  assign m_bus.arsize  = r_payload.size;
  assign m_bus.arburst = r_payload.burst;
  assign w_ar_hs       = m_bus.arvalid && m_bus.arready;

  // Source arready is a one-cycle pulse on the downstream handshake.
  assign s0_bus.arready = w_ar_hs && (r_gnt == ARB_PORT_IFU);
  assign s1_bus.arready = w_ar_hs && (r_gnt == ARB_PORT_LSU);

  // R path: zero-latency steer on the routing bit; gated in reset so all valid/ready read 0.
  assign w_rport = m_bus.rid[ID_W];
  assign w_rdata = m_bus.rdata;

  assign s0_bus.rvalid = !rst && m_bus.rvalid && (w_rport == ARB_PORT_IFU);
  assign s1_bus.rvalid = !rst && m_bus.rvalid && (w_rport == ARB_PORT_LSU);
  assign s0_bus.rid    = m_bus.rid[ID_W-1:0];
  assign s1_bus.rid    = m_bus.rid[ID_W-1:0];
  assign s0_bus.rdata  = w_rdata;
  assign s1_bus.rdata  = w_rdata;
  assign s0_bus.rresp  = m_bus.rresp;
  assign s1_bus.rresp  = m_bus.rresp;
  assign s0_bus.rlast  = m_bus.rlast;
  assign s1_bus.rlast  = m_bus.rlast;
  assign m_bus.rready  = !rst && ((w_rport == ARB_PORT_LSU) ? s1_bus.rready : s0_bus.rready);

  assign w_rlast_hs = m_bus.rvalid && m_bus.rready && m_bus.rlast;

  ifu_axi_rd_otcnt #(
    .MAX_OUTS(MAX_OUTS)
  ) u_otcnt0 (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_ar_hs && (r_gnt == ARB_PORT_IFU)),
    .i_dec (w_rlast_hs && (w_rport == ARB_PORT_IFU)),
    .o_full(w_full0)
  );

  ifu_axi_rd_otcnt #(
    .MAX_OUTS(MAX_OUTS)
  ) u_otcnt1 (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_ar_hs && (r_gnt == ARB_PORT_LSU)),
    .i_dec (w_rlast_hs && (w_rport == ARB_PORT_LSU)),
    .o_full(w_full1)
  );

endmodule
